// File: rtl/jk_pkg.sv
// Shared types and constants for the J/K flip-flop bank driver.
// The {J,K} encodings match the jk_flipflop responder's truth table.
package jk_pkg;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_DRIVE   = 3'd1,
    S_SETTLE  = 3'd2,
    S_CHECK   = 3'd3,
    S_RESPOND = 3'd4
  } state_e;

  localparam logic [1:0] JK_HOLD   = 2'b00;
  localparam logic [1:0] JK_RESET  = 2'b01;
  localparam logic [1:0] JK_SET    = 2'b10;
  localparam logic [1:0] JK_TOGGLE = 2'b11;

endpackage

// File: rtl/jk_excite.sv
// Per-bit J/K excitation: chooses the {J,K} pair that moves q toward target.
// Masked-off or already-correct bits are held.
module jk_excite
  import jk_pkg::*;
(
  input  logic q,
  input  logic target,
  input  logic mask,
  input  logic toggle_mode,
  output logic j,
  output logic k
);

  logic [1:0] jk_s;

  // Select hold, set, reset or toggle for this bit
  always_comb begin
    jk_s = JK_HOLD;
    if (!mask || (q == target)) begin
      jk_s = JK_HOLD;
    end else if (toggle_mode) begin
      jk_s = JK_TOGGLE;
    end else if (target) begin
      jk_s = JK_SET;
    end else begin
      jk_s = JK_RESET;
    end
  end

  assign {j, k} = jk_s;

endmodule

// File: rtl/jk_bank_driver.sv
// Drives an external J/K flip-flop bank to a requested value, waits for it to
// settle, reads Q back and retries a bounded number of times on mismatch.
module jk_bank_driver
  import jk_pkg::*;
#(
  parameter int WIDTH       = 4,
  parameter int SETTLE      = 2,
  parameter int MAX_RETRY   = 3,
  parameter int TOGGLE_MODE = 0
) (
  input  logic             clock,
  input  logic             clear,
  input  logic [WIDTH-1:0] target,
  input  logic [WIDTH-1:0] mask,
  input  logic             target_valid,
  output logic             target_ready,
  input  logic [WIDTH-1:0] q_in,
  output logic [WIDTH-1:0] j_out,
  output logic [WIDTH-1:0] k_out,
  output logic             ff_strobe,
  output logic             done,
  output logic             error,
  output logic             busy
);

  localparam logic [3:0] SETTLE_LAST = 4'(SETTLE - 1);
  localparam logic [2:0] RETRY_MAX   = 3'(MAX_RETRY);
  localparam logic       TOGGLE_EN   = (TOGGLE_MODE != 0);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] target_q, target_d;
  logic [WIDTH-1:0] mask_q, mask_d;
  logic [WIDTH-1:0] j_q, j_d;
  logic [WIDTH-1:0] k_q, k_d;
  logic [2:0]       retry_q, retry_d;
  logic [3:0]       settle_q, settle_d;
  logic             strobe_q, strobe_d;
  logic             done_q, done_d;
  logic             error_q, error_d;
  logic             ready_q, ready_d;
  logic             busy_q, busy_d;

  logic [WIDTH-1:0] exc_tgt_s, exc_mask_s, exc_j_s, exc_k_s;
  logic             match_s;

  // Drive is computed on the edge that enters DRIVE, so the accepting cycle
  // must use the live request while retries use the captured one.
  always_comb begin
    exc_tgt_s  = target_q;
    exc_mask_s = mask_q;
    if (state_q == S_IDLE) begin
      exc_tgt_s  = target;
      exc_mask_s = mask;
    end else begin
      exc_tgt_s  = target_q;
      exc_mask_s = mask_q;
    end
  end

  for (genvar i = 0; i < WIDTH; i++) begin : g_exc
    jk_excite u_exc (
      .q          (q_in[i]),
      .target     (exc_tgt_s[i]),
      .mask       (exc_mask_s[i]),
      .toggle_mode(TOGGLE_EN),
      .j          (exc_j_s[i]),
      .k          (exc_k_s[i])
    );
  end

  assign match_s = (((q_in ^ target_q) & mask_q) == '0);

  // Sequencing: accept, drive, settle, check (with retry), respond
  always_comb begin
    state_d  = state_q;
    target_d = target_q;
    mask_d   = mask_q;
    retry_d  = retry_q;
    settle_d = settle_q;
    case (state_q)
      S_IDLE: begin
        if (target_valid) begin
          state_d  = S_DRIVE;
          target_d = target;
          mask_d   = mask;
          retry_d  = 3'd0;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_DRIVE: begin
        state_d  = S_SETTLE;
        settle_d = 4'd0;
      end
      S_SETTLE: begin
        if (settle_q == SETTLE_LAST) begin
          state_d = S_CHECK;
        end else begin
          settle_d = settle_q + 4'd1;
        end
      end
      S_CHECK: begin
        if (match_s) begin
          state_d = S_RESPOND;
        end else if (retry_q < RETRY_MAX) begin
          retry_d = retry_q + 3'd1;
          state_d = S_DRIVE;
        end else begin
          state_d = S_RESPOND;
        end
      end
      S_RESPOND: state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  // Registered outputs are derived from the next state so they line up with it
  always_comb begin
    strobe_d = (state_d == S_DRIVE);
    j_d      = '0;
    k_d      = '0;
    if (strobe_d) begin
      j_d = exc_j_s;
      k_d = exc_k_s;
    end else begin
      j_d = '0;
      k_d = '0;
    end
    done_d  = (state_q == S_CHECK) && match_s;
    error_d = (state_q == S_CHECK) && !match_s && (retry_q >= RETRY_MAX);
    ready_d = (state_d == S_IDLE);
    busy_d  = (state_d != S_IDLE);
  end

  // State and output registers
  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      state_q  <= S_IDLE;
      target_q <= '0;
      mask_q   <= '0;
      retry_q  <= 3'd0;
      settle_q <= 4'd0;
      j_q      <= '0;
      k_q      <= '0;
      strobe_q <= 1'b0;
      done_q   <= 1'b0;
      error_q  <= 1'b0;
      ready_q  <= 1'b1;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      target_q <= target_d;
      mask_q   <= mask_d;
      retry_q  <= retry_d;
      settle_q <= settle_d;
      j_q      <= j_d;
      k_q      <= k_d;
      strobe_q <= strobe_d;
      done_q   <= done_d;
      error_q  <= error_d;
      ready_q  <= ready_d;
      busy_q   <= busy_d;
    end
  end

  assign j_out        = j_q;
  assign k_out        = k_q;
  assign ff_strobe    = strobe_q;
  assign done         = done_q;
  assign error        = error_q;
  assign target_ready = ready_q;
  assign busy         = busy_q;

endmodule

// File: tb/tb_jk_bank_driver.sv
// Randomized bench for jk_bank_driver: two instances (set/reset with 3 retries,
// toggle with no retries) each driving a behavioural J/K bank with stuck-at-0 bits.
module tb_jk_bank_driver;

  localparam int SETTLE = 2;

  logic       clock = 1'b0;
  logic       clear;
  logic [3:0] tgt[2];
  logic [3:0] msk[2];
  logic [3:0] j_o[2];
  logic [3:0] k_o[2];
  logic [3:0] stuck0[2];
  logic [3:0] qb[2] = '{4'h0, 4'h0};
  logic       tv[2];
  logic       rdy[2];
  logic       stb[2];
  logic       dn[2];
  logic       er[2];
  logic       bsy[2];

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clock = ~clock;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    jk_bank_driver #(
      .WIDTH      (4),
      .SETTLE     (SETTLE),
      .MAX_RETRY  ((g == 0) ? 3 : 0),
      .TOGGLE_MODE(g)
    ) u_dut (
      .clock       (clock),
      .clear       (clear),
      .target      (tgt[g]),
      .mask        (msk[g]),
      .target_valid(tv[g]),
      .target_ready(rdy[g]),
      .q_in        (qb[g]),
      .j_out       (j_o[g]),
      .k_out       (k_o[g]),
      .ff_strobe   (stb[g]),
      .done        (dn[g]),
      .error       (er[g]),
      .busy        (bsy[g])
    );

    // Behavioural J/K bank: Q+ = J&~Q | ~K&Q on strobe; stuck bits read 0
    always @(posedge clock) begin
      if (stb[g]) qb[g] <= ((j_o[g] & ~qb[g]) | (~k_o[g] & qb[g])) & ~stuck0[g];
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference excitation: changed bits go toward target, or toggle
  task automatic exp_jk(input logic [3:0] q, input logic [3:0] t, input logic [3:0] m,
                        input int tog, output logic [3:0] j, output logic [3:0] k);
    logic [3:0] ch;
    ch = (q ^ t) & m;
    if (tog != 0) begin
      j = ch;
      k = ch;
    end else begin
      j = ch & t;
      k = ch & ~t;
    end
  endtask

  task automatic run_req(input int d, input logic [3:0] t, input logic [3:0] m);
    logic [3:0] ej, ek, exp_q;
    int strobes, last_stb, mr, cyc;
    bit exp_err, fin;
    mr      = (d == 0) ? 3 : 0;
    exp_err = ((t & m & stuck0[d]) != 4'h0);
    exp_q   = ((qb[d] & ~m) | (t & m)) & ~stuck0[d];
    cyc = 0;
    while (!rdy[d] && cyc < 20) begin
      @(negedge clock);
      cyc++;
    end
    chk("ready", 32'(rdy[d]), 32'd1);
    tgt[d] = t;
    msk[d] = m;
    tv[d]  = 1'b1;
    @(negedge clock);
    tv[d]  = 1'b0;
    tgt[d] = 4'($urandom);
    msk[d] = 4'($urandom);
    chk("strobe_latency", 32'(stb[d]), 32'd1);
    strobes = 0; last_stb = 0; fin = 1'b0;
    for (int c = 0; c < 100 && !fin; c++) begin
      if (stb[d]) begin
        strobes++;
        last_stb = c;
        exp_jk(qb[d], t, m, d, ej, ek);
        chk("j_out", 32'(j_o[d]), 32'(ej));
        chk("k_out", 32'(k_o[d]), 32'(ek));
      end
      chk("done_error_excl", 32'(dn[d] & er[d]), 32'd0);
      if (dn[d] || er[d]) begin
        fin = 1'b1;
        chk("done", 32'(dn[d]), 32'(!exp_err));
        chk("error", 32'(er[d]), 32'(exp_err));
        chk("latency", 32'(c - last_stb), 32'(2 + SETTLE));
        chk("strobes", 32'(strobes), exp_err ? 32'(mr + 1) : 32'd1);
        chk("final_q", 32'(qb[d]), 32'(exp_q));
      end else begin
        @(negedge clock);
      end
    end
    if (!fin) chk("timeout", 32'd0, 32'd1);
    @(negedge clock);
    chk("ready_after", 32'(rdy[d]), 32'd1);
    chk("pulse_width", 32'(dn[d] | er[d]), 32'd0);
    chk("busy_after", 32'(bsy[d]), 32'd0);
  endtask

  task automatic back_to_back();
    logic [3:0] ej, ek;
    int cyc, dones;
    dones = 0;
    tgt[0] = 4'h3; msk[0] = 4'hF; tv[0] = 1'b1;
    @(negedge clock);
    chk("b2b_strobe1", 32'(stb[0]), 32'd1);
    tgt[0] = 4'hF;
    cyc = 0;
    while (!dn[0] && cyc < 30) begin
      @(negedge clock);
      cyc++;
    end
    chk("b2b_done1", 32'(dn[0]), 32'd1);
    dones += int'(dn[0]);
    chk("b2b_q1", 32'(qb[0]), 32'h3);
    tgt[0] = 4'hC;
    @(negedge clock);
    chk("b2b_ready", 32'(rdy[0]), 32'd1);
    @(negedge clock);
    chk("b2b_strobe2", 32'(stb[0]), 32'd1);
    exp_jk(qb[0], 4'hC, 4'hF, 0, ej, ek);
    chk("b2b_j2", 32'(j_o[0]), 32'(ej));
    chk("b2b_k2", 32'(k_o[0]), 32'(ek));
    tv[0] = 1'b0;
    cyc = 0;
    while (!dn[0] && cyc < 30) begin
      @(negedge clock);
      cyc++;
    end
    dones += int'(dn[0]);
    chk("b2b_dones", 32'(dones), 32'd2);
    chk("b2b_q2", 32'(qb[0]), 32'hC);
    @(negedge clock);
  endtask

  task automatic reset_mid();
    int dones;
    tgt[0] = 4'($urandom); msk[0] = 4'hF; tv[0] = 1'b1;
    @(negedge clock);
    tv[0] = 1'b0;
    @(negedge clock);
    #2 clear = 1'b1;
    #1;
    chk("rst_j", 32'(j_o[0]), 32'd0);
    chk("rst_k", 32'(k_o[0]), 32'd0);
    chk("rst_strobe", 32'(stb[0]), 32'd0);
    chk("rst_busy", 32'(bsy[0]), 32'd0);
    chk("rst_ready", 32'(rdy[0]), 32'd1);
    chk("rst_done_err", 32'(dn[0] | er[0]), 32'd0);
    @(negedge clock);
    clear = 1'b0;
    dones = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clock);
      dones += int'(dn[0] | er[0] | stb[0]);
    end
    chk("rst_no_pulse", 32'(dones), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    clear = 1'b1;
    for (int d = 0; d < 2; d++) begin
      tv[d] = 1'b0; tgt[d] = 4'h0; msk[d] = 4'h0; stuck0[d] = 4'h0;
    end
    @(negedge clock);
    @(negedge clock);
    for (int d = 0; d < 2; d++) begin
      chk("reset_outputs", {27'd0, j_o[d] != 4'h0, k_o[d] != 4'h0, stb[d], dn[d] | er[d], bsy[d]}, 32'd0);
      chk("reset_ready", 32'(rdy[d]), 32'd1);
    end
    clear = 1'b0;
    @(negedge clock);

    run_req(0, 4'b0101, 4'hF);
    run_req(0, 4'b1010, 4'hF);
    run_req(0, 4'b0000, 4'hF);
    run_req(0, 4'b1111, 4'b0011);
    run_req(0, 4'b1111, 4'b0000);
    run_req(0, 4'b0011, 4'b0011);
    stuck0[0] = 4'b0100;
    run_req(0, 4'b0100, 4'hF);
    stuck0[0] = 4'h0;
    back_to_back();
    reset_mid();
    for (int n = 0; n < 25; n++) begin
      stuck0[0] = ($urandom_range(0, 3) == 0) ? 4'(1 << $urandom_range(0, 3)) : 4'h0;
      run_req(0, 4'($urandom), 4'($urandom));
    end
    stuck0[0] = 4'h0;

    run_req(1, 4'b0011, 4'hF);
    run_req(1, 4'b0110, 4'hF);
    stuck0[1] = 4'b1000;
    run_req(1, 4'b1000, 4'hF);
    for (int n = 0; n < 15; n++) begin
      stuck0[1] = ($urandom_range(0, 3) == 0) ? 4'(1 << $urandom_range(0, 3)) : 4'h0;
      run_req(1, 4'($urandom), 4'($urandom));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
